// File: rtl/uart.sv
// uart: memory-mapped 8N1 UART with TX/RX FIFOs, sticky error flags and a programmable baud divisor.
module uart #(
  parameter int FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET = 16'd234
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  input  logic        rx,
  output logic        tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_state_t;
  tx_state_t ts;
  rx_state_t rs;
  logic [7:0] tmem [FIFO_DEPTH];
  logic [7:0] rmem [FIFO_DEPTH];
  logic [AW-1:0] twp, trp, rwp, rrp;
  logic [AW:0] tcnt, rcnt;
  logic [15:0] div, d, tbc, rbc;
  logic [7:0] tsh, rsh, rx_head;
  logic [2:0] tbi, rbi;
  logic s1, s2, tx_ovf, rx_ovr, frm_err;
  logic sel, tx_full, tx_empty, rx_full, rx_empty;
  logic tx_wr, tx_push, tx_pop, rx_pop, rx_smp, rx_push, fe_set, st_wr;
  logic [1:0] idx;
  logic [31:0] status;
  logic unused_bits;
  assign unused_bits = ^{size, addr[1:0], wd[31:16]};
  assign d = (div == 16'd0) ? 16'd1 : div;
  assign sel = addr[31:4] == 28'd0;
  assign idx = addr[3:2];
  assign tx_full = tcnt == (AW+1)'(FIFO_DEPTH);
  assign tx_empty = tcnt == '0;
  assign rx_full = rcnt == (AW+1)'(FIFO_DEPTH);
  assign rx_empty = rcnt == '0;
  assign tx_wr = we && sel && idx == 2'd0;
  assign tx_push = tx_wr && !tx_full;
  assign tx_pop = ts == T_IDLE && !tx_empty;
  assign rx_pop = we && sel && idx == 2'd1 && !rx_empty;
  assign st_wr = we && sel && idx == 2'd2;
  // stop-bit sample: high delivers the byte, low is a framing error
  assign rx_smp = rs == R_STOP && rbc == 16'd0 && s2;
  assign fe_set = rs == R_STOP && rbc == 16'd0 && !s2;
  assign rx_push = rx_smp && !rx_full;
  assign rx_head = rx_empty ? 8'd0 : rmem[rrp];
  assign status = {24'b0, tx_ovf, frm_err, rx_ovr, rx_full, rx_empty, ts != T_IDLE, tx_empty, tx_full};
  assign rd = !sel ? 32'd0 : idx == 2'd1 ? {23'b0, !rx_empty, rx_head} : idx == 2'd2 ? status :
              idx == 2'd3 ? {16'b0, div} : 32'd0;
  always_ff @(posedge clk) begin
    if (tx_push) tmem[twp] <= wd[7:0];
    if (rx_push) rmem[rwp] <= rsh;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ts <= T_IDLE;
      rs <= R_IDLE;
      twp <= '0;
      trp <= '0;
      rwp <= '0;
      rrp <= '0;
      tcnt <= '0;
      rcnt <= '0;
      div <= DIV_RESET;
      tbc <= '0;
      rbc <= '0;
      tsh <= '0;
      rsh <= '0;
      tbi <= '0;
      rbi <= '0;
      s1 <= 1'b1;
      s2 <= 1'b1;
      tx <= 1'b1;
      tx_ovf <= 1'b0;
      rx_ovr <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      s1 <= rx;
      s2 <= s1;
      if (we && sel && idx == 2'd3) div <= wd[15:0];
      tx_ovf <= (tx_wr && tx_full) || (tx_ovf && !(st_wr && wd[7]));
      rx_ovr <= (rx_smp && rx_full) || (rx_ovr && !(st_wr && wd[5]));
      frm_err <= fe_set || (frm_err && !(st_wr && wd[6]));
      if (tx_push) twp <= twp + AW'(1);
      if (tx_pop) trp <= trp + AW'(1);
      tcnt <= tcnt + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
      if (rx_push) rwp <= rwp + AW'(1);
      if (rx_pop) rrp <= rrp + AW'(1);
      rcnt <= rcnt + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
      tbc <= (ts == T_IDLE || tbc == 16'd0) ? d - 16'd1 : tbc - 16'd1;
      case (ts)
        T_IDLE: if (tx_pop) begin
          ts <= T_START;
          tsh <= tmem[trp];
          tx <= 1'b0;
        end
        T_START: if (tbc == 16'd0) begin
          ts <= T_DATA;
          tx <= tsh[0];
          tsh <= {1'b0, tsh[7:1]};
          tbi <= 3'd0;
        end
        T_DATA: if (tbc == 16'd0) begin
          tbi <= tbi + 3'd1;
          ts <= (tbi == 3'd7) ? T_STOP : T_DATA;
          tx <= (tbi == 3'd7) ? 1'b1 : tsh[0];
          tsh <= {1'b0, tsh[7:1]};
        end
        T_STOP: if (tbc == 16'd0) ts <= T_IDLE;
      endcase
      rbc <= (rbc == 16'd0) ? d - 16'd1 : rbc - 16'd1;
      case (rs)
        R_IDLE: begin
          rbc <= d >> 1;
          if (!s2) rs <= R_START;
        end
        R_START: if (rbc == 16'd0) begin
          rs <= s2 ? R_IDLE : R_DATA;
          rbi <= 3'd0;
        end
        R_DATA: if (rbc == 16'd0) begin
          rsh <= {s2, rsh[7:1]};
          rbi <= rbi + 3'd1;
          if (rbi == 3'd7) rs <= R_STOP;
        end
        R_STOP: if (rbc == 16'd0) rs <= s2 ? R_IDLE : R_BREAK;
        R_BREAK: if (s2) rs <= R_IDLE;
        default: rs <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart.sv
// tb_uart: directed self-checking bench for the memory-mapped UART.
module tb_uart;
  logic clk = 0, rstn = 0, we = 0, rx_drv = 1, lb = 0, mon_en = 0;
  logic [31:0] addr = 0, wd = 0, rd;
  logic [2:0] size = 0;
  logic tx_w, rx_w;
  int vecs = 0, errs = 0, mdiv = 4;
  logic [8:0] mq [$];

  assign rx_w = lb ? tx_w : rx_drv;
  always #5 clk = ~clk;

  uart #(.FIFO_DEPTH(4), .DIV_RESET(16'd234)) dut (
    .clk(clk), .rstn(rstn), .we(we), .addr(addr), .size(size),
    .wd(wd), .rd(rd), .rx(rx_w), .tx(tx_w)
  );

  // line monitor: decodes tx frames at the current mdiv into {stop, byte}
  always begin
    logic [8:0] f;
    @(posedge clk); #1;
    if (mon_en && tx_w === 1'b0) begin
      repeat (mdiv + mdiv / 2) @(posedge clk);
      #1 f[0] = tx_w;
      for (int i = 1; i < 9; i++) begin
        repeat (mdiv) @(posedge clk);
        #1 f[i] = tx_w;
      end
      mq.push_back(f);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wd = d; we = 1;
    @(posedge clk); #1;
    we = 0;
  endtask

  task automatic rdreg(input logic [31:0] a, output logic [31:0] v);
    addr = a;
    #1 v = rd;
  endtask

  task automatic wait_tx_idle(input int lim);
    logic [31:0] v;
    int n = 0;
    rdreg(8, v);
    while (!(v[1] && !v[2]) && n < lim) begin
      @(posedge clk); #1;
      rdreg(8, v);
      n++;
    end
    if (n >= lim) begin
      vecs++; errs++;
      $display("FAIL tx_idle_timeout: status %h after %0d cycles, want tx empty and idle", v, n);
    end
  endtask

  task automatic wait_rx_valid(input int lim);
    logic [31:0] v;
    int n = 0;
    rdreg(4, v);
    while (!v[8] && n < lim) begin
      @(posedge clk); #1;
      rdreg(4, v);
      n++;
    end
    if (n >= lim) begin
      vecs++; errs++;
      $display("FAIL rx_valid_timeout: rxdata %h after %0d cycles, want valid", v, n);
    end
  endtask

  // called on a negedge; fixed 4-cycle bit period
  task automatic drive_frame(input logic [7:0] b, input logic stop);
    rx_drv = 0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (4) @(negedge clk);
    end
    rx_drv = stop;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [31:0] v;
    rstn = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rstn = 1;
    @(posedge clk); #1;
    rdreg(8, v); vecs++;
    if (v !== 32'h0A) begin errs++; $display("FAIL reset_status: got %h want %h", v, 32'h0A); end
    rdreg(12, v); vecs++;
    if (v !== 32'd234) begin errs++; $display("FAIL reset_div: got %h want %h", v, 32'd234); end
    rdreg(4, v); vecs++;
    if (v !== 32'd0) begin errs++; $display("FAIL reset_rxdata: got %h want 0", v); end
    vecs++;
    if (tx_w !== 1'b1) begin errs++; $display("FAIL reset_tx: got %b want 1", tx_w); end
  endtask

  task automatic test_tx_single;
    logic [31:0] v;
    logic [9:0] f;
    f = {1'b1, 8'hA5, 1'b0};
    wr(12, 4);
    wr(0, 32'hA5);
    vecs++;
    if (tx_w !== 1'b1) begin errs++; $display("FAIL tx_early: got %b want 1", tx_w); end
    addr = 8;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 4; j++) begin
        vecs++;
        if (tx_w !== f[i]) begin errs++; $display("FAIL tx_bit%0d_c%0d: got %b want %b", i, j, tx_w, f[i]); end
        vecs++;
        if (rd[2] !== 1'b1) begin errs++; $display("FAIL tx_busy%0d_c%0d: got %b want 1", i, j, rd[2]); end
        @(posedge clk); #1;
      end
    rdreg(8, v); vecs++;
    if (v !== 32'h0A) begin errs++; $display("FAIL tx_done_status: got %h want %h", v, 32'h0A); end
  endtask

  task automatic test_tx_overflow;
    logic [31:0] v;
    logic [7:0] b [6];
    b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    mq.delete(); mdiv = 4; mon_en = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      addr = 0; wd = {24'b0, b[i]}; we = 1;
    end
    @(posedge clk); #1;
    we = 0;
    rdreg(8, v); vecs++;
    if (v !== 32'h8D) begin errs++; $display("FAIL ovf_status: got %h want %h", v, 32'h8D); end
    wait_tx_idle(400);
    mon_en = 0;
    vecs++;
    if (mq.size() != 5) begin errs++; $display("FAIL ovf_frames: got %0d want 5", mq.size()); end
    for (int i = 0; i < 5 && i < mq.size(); i++) begin
      vecs++;
      if (mq[i] !== {1'b1, b[i]}) begin errs++; $display("FAIL ovf_frame%0d: got %h want %h", i, mq[i], {1'b1, b[i]}); end
    end
    rdreg(8, v); vecs++;
    if (v !== 32'h8A) begin errs++; $display("FAIL ovf_sticky: got %h want %h", v, 32'h8A); end
    wr(8, 32'h80);
    rdreg(8, v); vecs++;
    if (v !== 32'h0A) begin errs++; $display("FAIL ovf_clear: got %h want %h", v, 32'h0A); end
  endtask

  task automatic test_loopback;
    logic [31:0] v;
    lb = 1;
    wr(0, 32'h3C);
    wait_rx_valid(200);
    rdreg(4, v); vecs++;
    if (v !== 32'h13C) begin errs++; $display("FAIL lb_rxdata: got %h want %h", v, 32'h13C); end
    wr(4, 0);
    rdreg(4, v); vecs++;
    if (v !== 32'h0) begin errs++; $display("FAIL lb_pop: got %h want 0", v); end
    rdreg(8, v); vecs++;
    if (v[3] !== 1'b1) begin errs++; $display("FAIL lb_rx_empty: got %b want 1", v[3]); end
    wait_tx_idle(100);
    lb = 0;
  endtask

  task automatic test_rx_errors;
    logic [31:0] v;
    logic [7:0] ob [5];
    ob = '{8'hC1, 8'h02, 8'h7E, 8'hF0, 8'h99};
    @(negedge clk);
    drive_frame(8'h55, 1'b0);
    repeat (8) @(negedge clk);
    rdreg(8, v); vecs++;
    if (v !== 32'h4A) begin errs++; $display("FAIL frm_status: got %h want %h", v, 32'h4A); end
    rdreg(4, v); vecs++;
    if (v !== 32'h0) begin errs++; $display("FAIL frm_rxdata: got %h want 0", v); end
    @(negedge clk) rx_drv = 1;
    repeat (4) @(negedge clk);
    drive_frame(8'hA3, 1'b1);
    repeat (6) @(negedge clk);
    rdreg(4, v); vecs++;
    if (v !== 32'h1A3) begin errs++; $display("FAIL frm_recover: got %h want %h", v, 32'h1A3); end
    wr(4, 0);
    wr(8, 32'h40);
    rdreg(8, v); vecs++;
    if (v !== 32'h0A) begin errs++; $display("FAIL frm_clear: got %h want %h", v, 32'h0A); end
    @(negedge clk);
    for (int i = 0; i < 5; i++) drive_frame(ob[i], 1'b1);
    repeat (6) @(negedge clk);
    rdreg(8, v); vecs++;
    if (v !== 32'h32) begin errs++; $display("FAIL ovr_status: got %h want %h", v, 32'h32); end
    for (int i = 0; i < 4; i++) begin
      rdreg(4, v); vecs++;
      if (v !== {23'b0, 1'b1, ob[i]}) begin errs++; $display("FAIL ovr_byte%0d: got %h want %h", i, v, {23'b0, 1'b1, ob[i]}); end
      wr(4, 0);
    end
    rdreg(4, v); vecs++;
    if (v !== 32'h0) begin errs++; $display("FAIL ovr_drained: got %h want 0", v); end
    wr(8, 32'h20);
    rdreg(8, v); vecs++;
    if (v !== 32'h0A) begin errs++; $display("FAIL ovr_clear: got %h want %h", v, 32'h0A); end
    @(negedge clk) rx_drv = 0;
    @(negedge clk) rx_drv = 1;
    repeat (20) @(negedge clk);
    rdreg(4, v); vecs++;
    if (v !== 32'h0) begin errs++; $display("FAIL glitch_rxdata: got %h want 0", v); end
    rdreg(8, v); vecs++;
    if (v !== 32'h0A) begin errs++; $display("FAIL glitch_status: got %h want %h", v, 32'h0A); end
  endtask

  task automatic test_bus_bounds;
    logic [31:0] v;
    wr(32'h10, 32'hFF);
    rdreg(8, v); vecs++;
    if (v !== 32'h0A) begin errs++; $display("FAIL oob_write: got %h want %h", v, 32'h0A); end
    wr(32'h1C, 9);
    rdreg(12, v); vecs++;
    if (v !== 32'd4) begin errs++; $display("FAIL oob_div: got %h want 4", v); end
    rdreg(32'h14, v); vecs++;
    if (v !== 32'h0) begin errs++; $display("FAIL oob_read14: got %h want 0", v); end
    rdreg(32'h18, v); vecs++;
    if (v !== 32'h0) begin errs++; $display("FAIL oob_read18: got %h want 0", v); end
    rdreg(0, v); vecs++;
    if (v !== 32'h0) begin errs++; $display("FAIL txdata_read: got %h want 0", v); end
  endtask

  task automatic test_div_zero;
    logic [31:0] v;
    wr(12, 0);
    rdreg(12, v); vecs++;
    if (v !== 32'h0) begin errs++; $display("FAIL div0_read: got %h want 0", v); end
    mq.delete(); mdiv = 1; mon_en = 1;
    wr(0, 32'h55);
    addr = 8;
    @(posedge clk); #1; vecs++;
    if (tx_w !== 1'b0) begin errs++; $display("FAIL div0_start: got %b want 0", tx_w); end
    @(posedge clk); #1; vecs++;
    if (tx_w !== 1'b1) begin errs++; $display("FAIL div0_bit0: got %b want 1", tx_w); end
    @(posedge clk); #1; vecs++;
    if (tx_w !== 1'b0) begin errs++; $display("FAIL div0_bit1: got %b want 0", tx_w); end
    repeat (7) @(posedge clk);
    #1 vecs++;
    if ({tx_w, rd[2]} !== 2'b11) begin errs++; $display("FAIL div0_stop: got tx,busy=%b want 11", {tx_w, rd[2]}); end
    @(posedge clk); #1; vecs++;
    if (rd[2] !== 1'b0) begin errs++; $display("FAIL div0_len: got busy %b want 0", rd[2]); end
    mon_en = 0;
    vecs++;
    if (mq.size() != 1 || mq[0] !== 9'h155) begin errs++; $display("FAIL div0_frame: got %0d frames, first %h want 1 frame 155", mq.size(), mq.size() > 0 ? mq[0] : 9'h0); end
    wr(12, 4);
  endtask

  task automatic test_back_to_back;
    logic [31:0] v;
    @(negedge clk);
    drive_frame(8'h5A, 1'b1);
    repeat (6) @(negedge clk);
    rdreg(4, v); vecs++;
    if (v !== 32'h15A) begin errs++; $display("FAIL same_preload: got %h want %h", v, 32'h15A); end
    @(negedge clk);
    fork
      drive_frame(8'hC3, 1'b1);
      begin
        repeat (41) @(posedge clk);
        @(negedge clk);
        addr = 4; we = 1;
        @(posedge clk); #1;
        we = 0;
      end
    join
    repeat (6) @(negedge clk);
    rdreg(4, v); vecs++;
    if (v !== 32'h1C3) begin errs++; $display("FAIL same_edge_head: got %h want %h", v, 32'h1C3); end
    rdreg(8, v); vecs++;
    if (v !== 32'h02) begin errs++; $display("FAIL same_edge_status: got %h want %h", v, 32'h02); end
    wr(4, 0);
    rdreg(4, v); vecs++;
    if (v !== 32'h0) begin errs++; $display("FAIL same_edge_count: got %h want 0", v); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    wr(0, 32'h00);
    repeat (8) @(posedge clk);
    #1 vecs++;
    if (tx_w !== 1'b0) begin errs++; $display("FAIL mid_frame_low: got %b want 0", tx_w); end
    #2 rstn = 0;
    #1 vecs++;
    if (tx_w !== 1'b1) begin errs++; $display("FAIL mid_reset_tx: got %b want 1", tx_w); end
    rdreg(8, v); vecs++;
    if (v !== 32'h0A) begin errs++; $display("FAIL mid_reset_status: got %h want %h", v, 32'h0A); end
    rdreg(12, v); vecs++;
    if (v !== 32'd234) begin errs++; $display("FAIL mid_reset_div: got %h want %h", v, 32'd234); end
    @(negedge clk) rstn = 1;
    repeat (50) @(posedge clk);
    #1 vecs++;
    if (tx_w !== 1'b1) begin errs++; $display("FAIL post_reset_tx: got %b want 1", tx_w); end
    rdreg(8, v); vecs++;
    if (v !== 32'h0A) begin errs++; $display("FAIL post_reset_status: got %h want %h", v, 32'h0A); end
  endtask

  initial begin
    test_reset;
    test_tx_single;
    test_tx_overflow;
    test_loopback;
    test_rx_errors;
    test_bus_bounds;
    test_div_zero;
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
